ifetch_ctrl32: RTL

Instruction-fetch and PC-update controller for the lab CPU: the producer of `PC_plus_4` and the consumer of `Add_Result`, `Zero` and the branch/jump controls that `Executs32` and the control unit produce. It fetches one instruction at a time from instruction memory over a req/ack handshake. It holds the instruction for decode/execute until commit, then resolves the next PC and starts the next fetch.

---
 rtl/ifetch_ctrl32_pkg.sv | 35 +++
 rtl/ifetch_ctrl32_next_pc_sel.sv | 33 +++
 rtl/ifetch_ctrl32.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ifetch_ctrl32_pkg.sv
// ifetch_ctrl32_pkg: shared definitions for the instruction-fetch controller.
//   - PC_RESET_DEF  : default byte address loaded into PC on reset
//   - fetch_state_e : FSM state encodings (IDLE / REQ / EXEC)
//   - pc_ctrl_t     : decoded control bundle feeding the next-PC mux
//   - OP_*          : MIPS opcode constants used by benches
//   - br_taken()    : conditional-branch resolution shared by the mux and the stats
package ifetch_ctrl32_pkg;

    localparam logic [31:0] PC_RESET_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_EXEC = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic jr;
        logic jmp;
        logic jal;
        logic branch;
        logic nbranch;
    } pc_ctrl_t;

    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;

    function automatic logic br_taken(input logic branch, input logic nbranch,
                                      input logic zero);
        return (branch & zero) | (nbranch & ~zero);
    endfunction

endpackage

// File: rtl/ifetch_ctrl32_next_pc_sel.sv
// next_pc_sel: combinational priority mux choosing the PC that follows a commit.
// Ports:
//   pc_plus_4   in  32 : PC of the held instruction + 4 (fall-through)
//   jump_index  in  26 : instruction[25:0] of the held instruction
//   target_word in  30 : branch target word address (Add_Result[29:0])
//   jr_word     in  30 : register jump target word (Read_data_1[31:2])
//   zero        in  1  : ALU zero flag
//   ctrl        in  5  : decoded jr/jmp/jal/branch/nbranch
//   next_pc     out 32 : selected next byte address
// Priority: jr > jmp|jal > taken branch > fall-through.
module next_pc_sel
    import ifetch_ctrl32_pkg::*;
(
    input  logic [31:0] pc_plus_4,
    input  logic [25:0] jump_index,
    input  logic [29:0] target_word,
    input  logic [29:0] jr_word,
    input  logic        zero,
    input  pc_ctrl_t    ctrl,
    output logic [31:0] next_pc
);

    always_comb begin
        next_pc = pc_plus_4;
        if (ctrl.jr)
            next_pc = {jr_word, 2'b00};
        else if (ctrl.jmp | ctrl.jal)
            next_pc = {pc_plus_4[31:28], jump_index, 2'b00};
        else if (br_taken(ctrl.branch, ctrl.nbranch, zero))
            next_pc = {target_word, 2'b00};
    end

endmodule

// File: rtl/ifetch_ctrl32.sv
// ifetch_ctrl32: instruction-fetch / PC-update controller.
// Fetches one instruction over a req/ack handshake, holds it until commit,
// then resolves the next PC and starts the next fetch (>= 2 cycles/instr).
// Ports:
//   clock, reset                 : single clock, synchronous active-high reset
//   imem_req/imem_addr           : fetch request and word address PC[IMEM_AW+1:2]
//   imem_ack/imem_rdata          : fetch response
//   instruction/inst_valid       : held instruction, valid until commit
//   commit                       : execute done, control inputs valid this cycle
//   Add_Result, Zero, Read_data_1, Branch, nBranch, Jmp, Jal, Jr : next-PC inputs
//   PC, PC_plus_4, link_addr     : held PC, PC+4, and PC+4 latched on a jal commit
// Optional: define BRANCH_STATS_EN to add saturating br_total_cnt / br_taken_cnt.
module ifetch_ctrl32
    import ifetch_ctrl32_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEF,
    parameter int          IMEM_AW  = 14
) (
    input  logic               clock,
    input  logic               reset,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        instruction,
    output logic               inst_valid,
    input  logic               commit,
    input  logic [31:0]        Add_Result,
    input  logic               Zero,
    input  logic [31:0]        Read_data_1,
    input  logic               Branch,
    input  logic               nBranch,
    input  logic               Jmp,
    input  logic               Jal,
    input  logic               Jr,
    output logic [31:0]        PC,
    output logic [31:0]        PC_plus_4,
    output logic [31:0]        link_addr
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]        br_total_cnt,
    output logic [15:0]        br_taken_cnt
`endif
);

    fetch_state_e state, state_nx;
    pc_ctrl_t     ctrl;
    logic [31:0]  next_pc;
    logic         capture;
    logic         do_commit;

    // Only the word-aligned part of these operands reaches the mux.
    logic unused_bits;
    assign unused_bits = ^{Add_Result[31:30], Read_data_1[1:0]};

    assign ctrl = '{jr: Jr, jmp: Jmp, jal: Jal, branch: Branch, nbranch: nBranch};

    // Handshakes are qualified by state so stray ack/commit are ignored.
    assign capture   = (state == ST_REQ)  & imem_ack;
    assign do_commit = (state == ST_EXEC) & commit;

    // Upper PC bits beyond the memory size are simply dropped.
    assign imem_addr = PC[IMEM_AW+1:2];

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        imem_req   = 1'b0;
        inst_valid = 1'b0;
        case (state)
            ST_IDLE: state_nx = ST_REQ;
            ST_REQ: begin
                imem_req = 1'b1;
                if (imem_ack) state_nx = ST_EXEC;
            end
            ST_EXEC: begin
                inst_valid = 1'b1;
                if (commit) state_nx = ST_REQ;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    next_pc_sel u_next_pc_sel (
        .pc_plus_4   (PC_plus_4),
        .jump_index  (instruction[25:0]),
        .target_word (Add_Result[29:0]),
        .jr_word     (Read_data_1[31:2]),
        .zero        (Zero),
        .ctrl        (ctrl),
        .next_pc     (next_pc)
    );

    // PC_plus_4 is kept as its own register so no adder sits on the output.
    always_ff @(posedge clock) begin
        if (reset) begin
            PC          <= PC_RESET;
            PC_plus_4   <= PC_RESET + 32'd4;
            instruction <= 32'h0;
            link_addr   <= 32'h0;
        end else begin
            if (capture) instruction <= imem_rdata;
            if (do_commit) begin
                PC        <= next_pc;
                PC_plus_4 <= next_pc + 32'd4;
                if (Jal) link_addr <= PC_plus_4;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    logic is_branch;
    assign is_branch = Branch | nBranch;

    always_ff @(posedge clock) begin
        if (reset) begin
            br_total_cnt <= 16'h0;
            br_taken_cnt <= 16'h0;
        end else if (do_commit && is_branch) begin
            if (br_total_cnt != 16'hFFFF)
                br_total_cnt <= br_total_cnt + 16'd1;
            if (br_taken(Branch, nBranch, Zero) && br_taken_cnt != 16'hFFFF)
                br_taken_cnt <= br_taken_cnt + 16'd1;
        end
    end
`endif

endmodule
